// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the two-requester ALU arbiter.
//   - state_t     : arbiter FSM states (IDLE, EXEC, RESP)
//   - OP_W        : ALU opcode width
//   - FLAG_*      : bit positions of the ALU flags inside a packed flag vector
//   - OP_*        : opcode encodings understood by the shared alu
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int OP_W = 3;

  localparam int NUM_FLAGS  = 4;
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two request channels and the response channel.
//   req0_* / req1_* : operation from requester 0 / 1 (valid, ready, a, b, op)
//   rsp_*           : tagged result channel (valid, ready, id, res, four flags)
// Modports: slave = the arbiter, master = requesters plus response consumer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Once valid is raised the sender holds it and its payload until the
// transfer. The arbiter's reqN_ready is combinational from reqN_valid, so a
// requester must never make valid depend on ready. rsp_valid is registered and
// the rsp_* payload stays constant for as long as rsp_ready is low.
interface alu_arbiter_if #(
  parameter int WIDTH = 6
);
  import alu_arb_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OP_W-1:0]  req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OP_W-1:0]  req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic             rsp_zero;
  logic             rsp_neg;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_res, rsp_carry, rsp_overflow, rsp_zero, rsp_neg
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_res, rsp_carry, rsp_overflow, rsp_zero, rsp_neg
  );

endinterface

// File: rtl/alu.sv
// alu: purely combinational WIDTH-bit ALU shared by the arbiter.
//   a, b     in  WIDTH  operands
//   op       in  OP_W   opcode (see OP_* in alu_arb_pkg)
//   res      out WIDTH  result
//   carry    out 1      add carry-out / subtract borrow / bit shifted out
//   overflow out 1      two's-complement overflow for add and subtract
//   zero     out 1      res is all zeros
//   neg      out 1      MSB of res
module alu
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit catches carry-out of the add and borrow of the subtract.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res      = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        res      = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res      = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res   = {a[WIDTH-2:0], 1'b0};
        carry = a[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, a[WIDTH-1:1]};
        carry = a[0];
      end
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);
  assign neg  = res[WIDTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters with round-robin grant.
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   bus       slave modport of alu_arbiter_if (two request channels + response)
//   busy      out  high whenever the FSM is not in IDLE
//   ops_done  out  CNT_W  wrapping count of completed response handshakes
//   dbg_state out  current FSM state
// Flow: IDLE accepts one operation and latches it, EXEC registers the alu
// outputs, RESP presents them until the consumer takes them.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 cur_id_q, cur_id_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_res_q, rsp_res_d;
  logic [NUM_FLAGS-1:0] rsp_flags_q, rsp_flags_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     ops_done_q, ops_done_d;

  logic                 grant0;
  logic                 grant1;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic                 alu_overflow;
  logic                 alu_zero;
  logic                 alu_neg;

  alu #(WIDTH) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .res      (alu_res),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero),
    .neg      (alu_neg)
  );

  // Grant decode. On a tie the requester that did not win last time goes,
  // so a requester holding valid high can never starve the other one.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_res_d    = rsp_res_q;
    rsp_flags_d  = rsp_flags_q;
    busy_d       = busy_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          a_d          = grant1 ? bus.req1_a  : bus.req0_a;
          b_d          = grant1 ? bus.req1_b  : bus.req0_b;
          op_d         = grant1 ? bus.req1_op : bus.req0_op;
          cur_id_d     = grant1;
          last_grant_d = grant1;
          busy_d       = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_res_d              = alu_res;
        rsp_flags_d[FLAG_CARRY] = alu_carry;
        rsp_flags_d[FLAG_OVF]   = alu_overflow;
        rsp_flags_d[FLAG_ZERO]  = alu_zero;
        rsp_flags_d[FLAG_NEG]   = alu_neg;
        rsp_id_d               = cur_id_q;
        rsp_valid_d            = 1'b1;
        state_d                = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          ops_done_d  = ops_done_q + CNT_ONE;
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      rsp_flags_q  <= '0;
      busy_q       <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_res_q    <= rsp_res_d;
      rsp_flags_q  <= rsp_flags_d;
      busy_q       <= busy_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_res      = rsp_res_q;
  assign bus.rsp_carry    = rsp_flags_q[FLAG_CARRY];
  assign bus.rsp_overflow = rsp_flags_q[FLAG_OVF];
  assign bus.rsp_zero     = rsp_flags_q[FLAG_ZERO];
  assign bus.rsp_neg      = rsp_flags_q[FLAG_NEG];
  assign busy             = busy_q;
  assign ops_done         = ops_done_q;
  assign dbg_state        = state_q;

endmodule
